half_adder: RTL and testbench

HALF_ADDER -- requirements
Module: half_adder

---
 rtl/half_adder.sv | 90 +++++++++
 tb/tb_half_adder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/half_adder.sv
// half_adder: WIDTH independent bit-slice half adders with a combinational
// sum/carry path, a registered copy qualified by in_valid, and a saturating
// counter of accepted cycles that produced any carry.
module half_adder #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic [WIDTH-1:0] sum_q,
  output logic [WIDTH-1:0] carry_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] carry_cnt
);

  // Saturating increment: sticks at all-ones instead of wrapping to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    logic [CNT_W-1:0] v_res;
    if (&val) begin
      v_res = val;
    end else begin
      v_res = val + CNT_W'(1);
    end
    return v_res;
  endfunction

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_carry;
  logic             w_any_carry;

  logic [WIDTH-1:0] r_sum_q;
  logic [WIDTH-1:0] r_carry_q;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_carry_cnt;

  // Per-slice half adders; bitwise operators keep slices independent, so no
  // carry ever ripples from slice i into slice i+1.
  always_comb begin
    w_sum       = a ^ b;
    w_carry     = a & b;
    w_any_carry = |w_carry;
  end

  // Registered result: load on accepted cycles, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum_q   <= {WIDTH{1'b0}};
      r_carry_q <= {WIDTH{1'b0}};
    end else if (in_valid) begin
      r_sum_q   <= w_sum;
      r_carry_q <= w_carry;
    end else begin
      r_sum_q   <= r_sum_q;
      r_carry_q <= r_carry_q;
    end
  end

  // out_valid is in_valid delayed by exactly one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
    end
  end

  // Count accepted cycles with any carry bit set, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_carry_cnt <= {CNT_W{1'b0}};
    end else if (in_valid && w_any_carry) begin
      r_carry_cnt <= sat_inc(r_carry_cnt);
    end else begin
      r_carry_cnt <= r_carry_cnt;
    end
  end

  assign sum       = w_sum;
  assign carry     = w_carry;
  assign sum_q     = r_sum_q;
  assign carry_q   = r_carry_q;
  assign out_valid = r_out_valid;
  assign carry_cnt = r_carry_cnt;

endmodule

// File: tb/tb_half_adder.sv
// tb_half_adder: directed, table-driven bench for half_adder. One instance
// uses the default WIDTH=1/CNT_W=16, a second uses WIDTH=4/CNT_W=4 for the
// multi-slice and counter-saturation cases.
module tb_half_adder;

  typedef struct packed {
    logic a;
    logic b;
    logic s;
    logic c;
  } vec1_t;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] s;
    logic [3:0] c;
  } vec4_t;

  logic        clk;
  logic        rst;

  logic        a1, b1, iv1;
  logic        sum1, carry1, sum_q1, carry_q1, ov1;
  logic [15:0] cnt1;

  logic [3:0]  a4, b4;
  logic        iv4;
  logic [3:0]  sum4, carry4, sum_q4, carry_q4;
  logic        ov4;
  logic [3:0]  cnt4;

  int n_checks;
  int n_fail;

  half_adder #(.WIDTH(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(iv1),
    .sum(sum1), .carry(carry1), .sum_q(sum_q1), .carry_q(carry_q1),
    .out_valid(ov1), .carry_cnt(cnt1)
  );

  half_adder #(.WIDTH(4), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .in_valid(iv4),
    .sum(sum4), .carry(carry4), .sum_q(sum_q4), .carry_q(carry_q4),
    .out_valid(ov4), .carry_cnt(cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive dut1 inputs at the falling edge, then sample 1 ns after the rising edge.
  task automatic step1(input logic ta, input logic tb, input logic tv);
    @(negedge clk);
    a1 = ta; b1 = tb; iv1 = tv;
    @(posedge clk);
    #1;
  endtask

  task automatic step4(input logic [3:0] ta, input logic [3:0] tb, input logic tv);
    @(negedge clk);
    a4 = ta; b4 = tb; iv4 = tv;
    @(posedge clk);
    #1;
  endtask

  vec1_t tbl1[4];
  vec4_t tbl4[6];
  int    exp_cnt;

  initial begin
    n_checks = 0;
    n_fail   = 0;

    tbl1[0] = '{a: 1'b0, b: 1'b0, s: 1'b0, c: 1'b0};
    tbl1[1] = '{a: 1'b0, b: 1'b1, s: 1'b1, c: 1'b0};
    tbl1[2] = '{a: 1'b1, b: 1'b0, s: 1'b1, c: 1'b0};
    tbl1[3] = '{a: 1'b1, b: 1'b1, s: 1'b0, c: 1'b1};

    tbl4[0] = '{a: 4'b1011, b: 4'b0110, s: 4'b1101, c: 4'b0010};
    tbl4[1] = '{a: 4'b1111, b: 4'b1111, s: 4'b0000, c: 4'b1111};
    tbl4[2] = '{a: 4'b0000, b: 4'b0000, s: 4'b0000, c: 4'b0000};
    tbl4[3] = '{a: 4'b1010, b: 4'b0101, s: 4'b1111, c: 4'b0000};
    tbl4[4] = '{a: 4'b0001, b: 4'b0001, s: 4'b0000, c: 4'b0001};
    tbl4[5] = '{a: 4'b1000, b: 4'b1100, s: 4'b0100, c: 4'b1000};

    rst = 1'b1;
    a1 = 1'b1; b1 = 1'b1; iv1 = 1'b0;
    a4 = 4'b0000; b4 = 4'b0000; iv4 = 1'b0;

    // Reset state, and combinational path alive during reset.
    #2;
    chk("rst_sum_q1",   32'(sum_q1),   32'd0);
    chk("rst_carry_q1", 32'(carry_q1), 32'd0);
    chk("rst_ov1",      32'(ov1),      32'd0);
    chk("rst_cnt1",     32'(cnt1),     32'd0);
    chk("rst_cnt4",     32'(cnt4),     32'd0);
    chk("rst_comb_sum",   32'(sum1),   32'd0);
    chk("rst_comb_carry", 32'(carry1), 32'd1);

    @(negedge clk);
    rst = 1'b0;
    a1 = 1'b0; b1 = 1'b0;
    #10;
    chk("idle00_sum",   32'(sum1),   32'd0);
    chk("idle00_carry", 32'(carry1), 32'd0);

    // Width-1 truth table, 10 ns per step.
    for (int i = 0; i < 4; i++) begin
      a1 = tbl1[i].a; b1 = tbl1[i].b;
      #10;
      chk($sformatf("tt1_sum[%0d]", i),   32'(sum1),   32'(tbl1[i].s));
      chk($sformatf("tt1_carry[%0d]", i), 32'(carry1), 32'(tbl1[i].c));
    end

    // Width-4 slices, including no ripple between slices.
    for (int i = 0; i < 6; i++) begin
      a4 = tbl4[i].a; b4 = tbl4[i].b;
      #1;
      chk($sformatf("tt4_sum[%0d]", i),   32'(sum4),   32'(tbl4[i].s));
      chk($sformatf("tt4_carry[%0d]", i), 32'(carry4), 32'(tbl4[i].c));
    end

    // Accept 1/1, then hold with in_valid low while inputs change.
    step1(1'b1, 1'b1, 1'b1);
    chk("acc11_sum_q",   32'(sum_q1),   32'd0);
    chk("acc11_carry_q", 32'(carry_q1), 32'd1);
    chk("acc11_ov",      32'(ov1),      32'd1);
    chk("acc11_cnt",     32'(cnt1),     32'd1);
    step1(1'b0, 1'b1, 1'b0);
    chk("hold_sum_q",   32'(sum_q1),   32'd0);
    chk("hold_carry_q", 32'(carry_q1), 32'd1);
    chk("hold_ov",      32'(ov1),      32'd0);
    chk("hold_cnt",     32'(cnt1),     32'd1);

    // Accepted cycle without carry leaves the counter alone.
    step1(1'b1, 1'b0, 1'b1);
    chk("acc10_sum_q",   32'(sum_q1),   32'd1);
    chk("acc10_carry_q", 32'(carry_q1), 32'd0);
    chk("acc10_cnt",     32'(cnt1),     32'd1);

    // Bring the counter to 5, finishing on a sum_q=1 result.
    for (int i = 0; i < 4; i++) step1(1'b1, 1'b1, 1'b1);
    step1(1'b1, 1'b0, 1'b1);
    chk("pre_rst_cnt",   32'(cnt1),   32'd5);
    chk("pre_rst_sum_q", 32'(sum_q1), 32'd1);

    // Mid-cycle async reset clears registers immediately, not the comb path.
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_sum_q",   32'(sum_q1),   32'd0);
    chk("mid_rst_carry_q", 32'(carry_q1), 32'd0);
    chk("mid_rst_ov",      32'(ov1),      32'd0);
    chk("mid_rst_cnt",     32'(cnt1),     32'd0);
    chk("mid_rst_sum",     32'(sum1),     32'd1);
    chk("mid_rst_carry",   32'(carry1),   32'd0);

    // First edge after release is a normal accept.
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; iv1 = 1'b1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_carry_q", 32'(carry_q1), 32'd1);
    chk("post_rst_ov",      32'(ov1),      32'd1);
    chk("post_rst_cnt",     32'(cnt1),     32'd1);
    iv1 = 1'b0;

    // CNT_W=4 saturation: 20 accepted carry cycles with a no-carry accept inside.
    exp_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 3) begin
        step4(4'b0011, 4'b0100, 1'b1);
        chk("nocarry_sum_q4", 32'(sum_q4), 32'h7);
        chk("nocarry_cnt4",   32'(cnt4),   32'(exp_cnt));
      end
      step4(4'b0001, 4'b0001, 1'b1);
      if (exp_cnt < 15) exp_cnt++;
      chk($sformatf("sat_cnt4[%0d]", i), 32'(cnt4), 32'(exp_cnt));
    end
    chk("sat_carry_q4", 32'(carry_q4), 32'h1);
    step4(4'b1111, 4'b1111, 1'b0);
    chk("idle_cnt4",     32'(cnt4),     32'd15);
    chk("idle_ov4",      32'(ov4),      32'd0);
    chk("idle_carry_q4", 32'(carry_q4), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
